// File: rtl/divisor_multicanal.sv
// divisor_multicanal: NCH-channel run-time programmable clock divider with square-wave and tick outputs.
// Optional feature macro DIV_SYNC_START_EN adds input 'sync' for a phase-aligned restart of all channels.
module divisor_multicanal #(
    parameter int NCH     = 2,
    parameter int CW      = 20,
    parameter int DEF_DIV = 999999
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] en,
    input  logic           load,
    input  logic [2:0]     load_ch,
    input  logic [CW-1:0]  load_val,
`ifdef DIV_SYNC_START_EN
    input  logic           sync,
`endif
    output logic [NCH-1:0] s_clk,
    output logic [NCH-1:0] tick
);

    localparam logic [CW-1:0] DEF_LIMIT = CW'(DEF_DIV);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] cuenta_reg, cuenta_next;
            logic [CW-1:0] limit_reg, limit_next;
            logic          s_clk_reg, s_clk_next;
            logic          tick_reg, tick_next;
            logic          load_hit;

            assign load_hit = load && (load_ch == 3'(gi));

            // A load beats a same-cycle terminal count: the phase restarts, no toggle.
            always_comb begin
                cuenta_next = cuenta_reg;
                limit_next  = limit_reg;
                s_clk_next  = s_clk_reg;
                tick_next   = 1'b0;
                if (load_hit) begin
                    limit_next  = load_val;
                    cuenta_next = '0;
                end else if (en[gi]) begin
                    if (cuenta_reg == limit_reg) begin
                        cuenta_next = '0;
                        s_clk_next  = ~s_clk_reg;
                        tick_next   = 1'b1;
                    end else begin
                        cuenta_next = cuenta_reg + CW'(1);
                    end
                end
`ifdef DIV_SYNC_START_EN
                // Global restart overrides phase state but keeps any same-cycle limit update.
                if (sync) begin
                    cuenta_next = '0;
                    s_clk_next  = 1'b0;
                    tick_next   = 1'b0;
                end
`endif
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cuenta_reg <= '0;
                    limit_reg  <= DEF_LIMIT;
                    s_clk_reg  <= 1'b0;
                    tick_reg   <= 1'b0;
                end else begin
                    cuenta_reg <= cuenta_next;
                    limit_reg  <= limit_next;
                    s_clk_reg  <= s_clk_next;
                    tick_reg   <= tick_next;
                end
            end

            assign s_clk[gi] = s_clk_reg;
            assign tick[gi]  = tick_reg;
        end
    endgenerate

endmodule
